// File: rtl/keypad_alu_seq_pkg.sv
// Shared types for the keypad/ALU sequencer: ALU opcodes, sequencer states and
// the scan-result encoding used by the keypad scanner.
package keypad_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MOV = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } seq_state_t;

  // A scan result is {empty, code}; bit 4 set means no key was seen.
  localparam logic [4:0] KEY_NONE = 5'h10;

  function automatic logic [1:0] lowest_row(input logic [3:0] row);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (row[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_alu_seq_if.sv
// Command/result bundle between the board-side controller and keypad_alu_seq.
interface keypad_alu_seq_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  import keypad_alu_pkg::*;

  // start is sampled only while busy is low; once taken, busy stays high for
  // three cycles and done pulses in the last of them alongside the new
  // result/flags. key_wr qualifies the scanner's one-cycle key_valid pulse.
  logic             key_wr;
  logic             start;
  logic [2:0]       op;
  logic [AW-1:0]    addr_a;
  logic [AW-1:0]    addr_b;
  logic [AW-1:0]    addr_d;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             carry_flag;
  seq_state_t       dbg_state;

  modport master (
    output key_wr, start, op, addr_a, addr_b, addr_d,
    input  busy, done, result, zero_flag, carry_flag, dbg_state
  );

  modport slave (
    input  key_wr, start, op, addr_a, addr_b, addr_d,
    output busy, done, result, zero_flag, carry_flag, dbg_state
  );

endinterface

// File: rtl/keypad_alu_seq_kb_scanner.sv
// 4x4 keypad scanner: one-hot column drive, end-of-slot row sampling, priority
// encoding (lowest column, then lowest row) and scan-level debounce.
module kb_scanner
  import keypad_alu_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kb_row,
  output logic [3:0] kb_col,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [DW-1:0] div_q;
  logic [1:0]    col_q;
  logic [4:0]    hit_q;
  logic [4:0]    prev_q;
  logic [CW-1:0] stab_q;
  logic          armed_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q;

  logic          slot_end;
  logic          scan_end;
  logic [4:0]    samp;
  logic [CW-1:0] stab_d;
  logic          accept;

  always_comb begin
    slot_end = (div_q == DW'(SCAN_DIV - 1));
    scan_end = slot_end && (col_q == 2'd3);
    // Earlier columns already recorded a hit take priority over this one.
    samp = hit_q;
    if (slot_end && (hit_q == KEY_NONE) && (|kb_row)) samp = {1'b0, col_q, lowest_row(kb_row)};
    stab_d = CW'(1);
    if ((samp != KEY_NONE) && (samp == prev_q)) begin
      stab_d = (stab_q == CW'(DEBOUNCE)) ? stab_q : stab_q + 1'b1;
    end
    accept = scan_end && (samp != KEY_NONE) && (stab_d == CW'(DEBOUNCE)) && armed_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      col_q       <= 2'd0;
      hit_q       <= KEY_NONE;
      prev_q      <= KEY_NONE;
      stab_q      <= '0;
      armed_q     <= 1'b1;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      key_valid_q <= 1'b0;
      if (slot_end) begin
        div_q <= '0;
        col_q <= col_q + 2'd1;
        if (col_q == 2'd3) begin
          hit_q  <= KEY_NONE;
          prev_q <= samp;
          stab_q <= stab_d;
          if (samp == KEY_NONE) armed_q <= 1'b1;
          if (accept) begin
            key_valid_q <= 1'b1;
            key_code_q  <= samp[3:0];
            armed_q     <= 1'b0;
          end
        end else begin
          hit_q <= samp;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign kb_col    = 4'b0001 << col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_alu_seq.sv
// Keypad-fed register bank with an 8-op ALU and a four-state sequencer that
// runs one operation per start and writes the result back.
module keypad_alu_seq
  import keypad_alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NREGS    = 4,
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       kb_row,
  output logic [3:0]       kb_col,
  output logic             key_valid,
  output logic [3:0]       key_code,
  keypad_alu_seq_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  seq_state_t       state_q, state_d;
  alu_op_t          op_q;
  logic [AW-1:0]    sa_q, sb_q, sd_q;
  logic [WIDTH-1:0] opa_q, opb_q, result_q;
  logic             zero_q, carry_q;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH:0]   ext;

  kb_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .kb_row    (kb_row),
    .kb_col    (kb_col),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ext[WIDTH] is the carry flag for every op; SUB stores "no borrow".
  always_comb begin
    ext = '0;
    case (op_q)
      OP_ADD: ext = {1'b0, opa_q} + {1'b0, opb_q};
      OP_SUB: begin
        ext        = {1'b0, opa_q} - {1'b0, opb_q};
        ext[WIDTH] = ~ext[WIDTH];
      end
      OP_AND: ext = {1'b0, opa_q & opb_q};
      OP_OR:  ext = {1'b0, opa_q | opb_q};
      OP_XOR: ext = {1'b0, opa_q ^ opb_q};
      OP_SHL: ext = {opa_q, 1'b0};
      OP_SHR: ext = {opa_q[0], 1'b0, opa_q[WIDTH-1:1]};
      OP_MOV: ext = {1'b0, opa_q};
      default: ext = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_ADD;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && bus.start) begin
        op_q <= alu_op_t'(bus.op);
        sa_q <= bus.addr_a;
        sb_q <= bus.addr_b;
        sd_q <= bus.addr_d;
      end
      if (state_q == S_READ) begin
        opa_q <= regs_q[sa_q];
        opb_q <= regs_q[sb_q];
      end
      if (state_q == S_EXEC) begin
        result_q <= ext[WIDTH-1:0];
        carry_q  <= ext[WIDTH];
        zero_q   <= (ext[WIDTH-1:0] == '0);
      end
    end
  end

  // ALU writeback has priority; a coinciding key write is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (state_q == S_WB) begin
      regs_q[sd_q] <= result_q;
    end else if (key_valid && bus.key_wr) begin
      regs_q[bus.addr_d] <= {{(WIDTH-4){1'b0}}, key_code};
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_WB);
  assign bus.result     = result_q;
  assign bus.zero_flag  = zero_q;
  assign bus.carry_flag = carry_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_keypad_alu_seq.sv
// Scoreboard bench for keypad_alu_seq: keypad matrix model, directed and random
// key presses and ALU operations, checked against an arithmetic reference model.
module tb_keypad_alu_seq;
  import keypad_alu_pkg::*;

  localparam int WIDTH    = 8;
  localparam int NREGS    = 4;
  localparam int AW       = 2;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  kb_row;
  logic [3:0]  kb_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] pressed;

  keypad_alu_seq_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  keypad_alu_seq #(
    .WIDTH    (WIDTH),
    .NREGS    (NREGS),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .kb_row    (kb_row),
    .kb_col    (kb_col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .bus       (bus)
  );

  // ---------------- clock / keypad matrix ----------------
  always #5 clk = ~clk;

  always_comb begin
    kb_row = 4'b0000;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (kb_col[c] && pressed[c*4 + r]) kb_row[r] = 1'b1;
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH+1:0] exp_q[$];      // {result, zero, carry}
  logic [3:0]       key_exp_q[$];
  logic [WIDTH-1:0] model_regs [NREGS];
  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  int key_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  always @(negedge clk) begin : monitor
    logic [WIDTH+1:0] e;
    logic [3:0] k;
    if (!reset) begin
      if (bus.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_done actual=%0h required=no_done", bus.result);
        end else begin
          e = exp_q.pop_front();
          check("alu_result_zero_carry", {bus.result, bus.zero_flag, bus.carry_flag}, 32'(e));
        end
      end
      if (key_valid) begin
        key_pulses++;
        if (key_exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_key_valid actual=%0h required=no_pulse", key_code);
        end else begin
          k = key_exp_q.pop_front();
          check("key_code", key_code, k);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [WIDTH+1:0] model_alu(input logic [2:0] op, input int a, input int b);
    int m, r, c;
    logic [WIDTH-1:0] rv;
    m = 1 << WIDTH;
    c = 0;
    case (op)
      3'd0: begin r = a + b; c = (r >= m) ? 1 : 0; end
      3'd1: begin r = a - b + m; c = (a >= b) ? 1 : 0; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a * 2; c = (a >= m / 2) ? 1 : 0; end
      3'd6: begin r = a / 2; c = a % 2; end
      default: r = a;
    endcase
    r  = r % m;
    rv = WIDTH'(r);
    return {rv, (r == 0), (c != 0)};
  endfunction

  function automatic logic [3:0] lowest_key(input logic [15:0] mask);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 15; i >= 0; i--) if (mask[i]) code = 4'(i);
    return code;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 20) begin @(negedge clk); n++; end
    if (bus.busy) timeout_fail("idle_wait");
  endtask

  task automatic wait_col_start(input logic [3:0] col);
    int n;
    n = 0;
    while (kb_col == col && n < 100) begin @(negedge clk); n++; end
    while (kb_col != col && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout_fail("col_wait");
  endtask

  task automatic do_op(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d);
    logic [WIDTH+1:0] e;
    int n;
    wait_idle();
    e = model_alu(op, int'(model_regs[a]), int'(model_regs[b]));
    exp_q.push_back(e);
    model_regs[d] = e[WIDTH+1:2];
    bus.start = 1'b1; bus.op = op; bus.addr_a = a; bus.addr_b = b; bus.addr_d = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    n = 0;
    while (!bus.done && n < 6) begin @(posedge clk); #1; n++; end
    check("done_latency", n, 2);
    @(posedge clk); #1;
    check("busy_after_wb", bus.busy, 0);
  endtask

  task automatic press_key(input logic [15:0] mask, input logic wr, input logic [AW-1:0] ad);
    int n0, n;
    logic [3:0] code;
    code = lowest_key(mask);
    bus.key_wr = wr;
    bus.addr_d = ad;
    key_exp_q.push_back(code);
    n0 = key_pulses;
    pressed = mask;
    n = 0;
    while (key_pulses == n0 && n < 200) begin @(negedge clk); #1; n++; end
    if (key_pulses == n0) timeout_fail("key_pulse_wait");
    else if (wr) model_regs[ad] = WIDTH'(code);
    repeat (60) @(negedge clk);
    pressed = '0;
    repeat (40) @(negedge clk);
    bus.key_wr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH+1:0] e;
    logic [15:0] mask;
    int n, d0;

    reset = 1'b1;
    pressed = '0;
    bus.start = 1'b0; bus.op = 3'd0; bus.key_wr = 1'b0;
    bus.addr_a = '0; bus.addr_b = '0; bus.addr_d = '0;
    for (int i = 0; i < NREGS; i++) model_regs[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_kb_col", kb_col, 4'b0001);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero_flag, 0);
    check("rst_carry", bus.carry_flag, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_state", bus.dbg_state, S_IDLE);

    // Key 9 (column 2, row 1) held from reset release: accepted after scan 2.
    key_exp_q.push_back(4'd9);
    pressed = 16'h0200;
    reset = 1'b0;
    n = 0;
    while (!key_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("key9_latency", n, 32);
    repeat (80) @(negedge clk);
    check("key_held_single", key_pulses, 1);
    pressed = '0;
    repeat (40) @(negedge clk);
    press_key(16'h0200, 1'b0, '0);
    check("key_repress", key_pulses, 2);

    press_key(16'h0050, 1'b0, '0);        // rows 0 and 2 in column 1
    press_key(16'h8000, 1'b1, 2'd0);      // 0xF -> r0
    press_key(16'h0002, 1'b1, 2'd1);      // 0x1 -> r1

    do_op(OP_ADD, 2'd0, 2'd1, 2'd2);
    do_op(OP_SUB, 2'd1, 2'd0, 2'd3);
    do_op(OP_MOV, 2'd2, 2'd2, 2'd0);
    for (int i = 0; i < 3; i++) do_op(OP_SHL, 2'd0, 2'd0, 2'd0);
    do_op(OP_SHL, 2'd0, 2'd0, 2'd3);
    do_op(OP_XOR, 2'd1, 2'd1, 2'd3);

    // start held for 12 cycles: three back-to-back dependent ADDs.
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      e = model_alu(OP_ADD, int'(model_regs[2]), int'(model_regs[2]));
      exp_q.push_back(e);
      model_regs[2] = e[WIDTH+1:2];
    end
    d0 = done_cnt;
    bus.op = OP_ADD; bus.addr_a = 2'd2; bus.addr_b = 2'd2; bus.addr_d = 2'd2;
    bus.start = 1'b1;
    repeat (12) @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("held_start_dones", done_cnt - d0, 3);

    // start kept high while busy with different operands: must be ignored.
    wait_idle();
    e = model_alu(OP_OR, int'(model_regs[0]), int'(model_regs[1]));
    exp_q.push_back(e);
    model_regs[3] = e[WIDTH+1:2];
    d0 = done_cnt;
    bus.op = OP_OR; bus.addr_a = 2'd0; bus.addr_b = 2'd1; bus.addr_d = 2'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.op = OP_SUB; bus.addr_a = 2'd3; bus.addr_b = 2'd2; bus.addr_d = 2'd1;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_start_ignored_dones", done_cnt - d0, 1);
    check("busy_start_ignored_idle", bus.busy, 0);

    // Reset while in EXEC aborts the ADD with no writeback.
    wait_idle();
    bus.op = OP_ADD; bus.addr_a = 2'd0; bus.addr_b = 2'd1; bus.addr_d = 2'd0;
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_state", bus.dbg_state, S_EXEC);
    reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_result", bus.result, 0);
    check("abort_done", bus.done, 0);
    for (int i = 0; i < NREGS; i++) model_regs[i] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_op(OP_MOV, 2'd0, 2'd0, 2'd1);

    // Randomised key loads and operations.
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) mask = 16'(1) << $urandom_range(0, 15);
      else mask = 16'($urandom_range(1, 16'hFFFF));
      press_key(mask, 1'b1, AW'($urandom_range(0, NREGS - 1)));
    end
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), AW'($urandom_range(0, NREGS - 1)),
            AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1)));
    end

    // Key acceptance lands in the WB cycle of an op targeting the same register.
    wait_idle();
    bus.key_wr = 1'b1;
    bus.addr_d = 2'd2;
    wait_col_start(4'b0001);
    pressed = 16'h0020;
    key_exp_q.push_back(4'd5);
    wait_col_start(4'b1000);
    wait_col_start(4'b0001);
    wait_col_start(4'b1000);
    @(negedge clk);
    e = model_alu(OP_ADD, int'(model_regs[0]), int'(model_regs[1]));
    exp_q.push_back(e);
    model_regs[2] = e[WIDTH+1:2];
    bus.op = OP_ADD; bus.addr_a = 2'd0; bus.addr_b = 2'd1;
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 6) begin @(posedge clk); #1; n++; end
    check("conflict_key_with_wb", key_valid, 1);
    repeat (30) @(negedge clk);
    pressed = '0;
    repeat (40) @(negedge clk);
    bus.key_wr = 1'b0;
    do_op(OP_MOV, 2'd2, 2'd2, 2'd3);

    repeat (20) @(negedge clk);
    check("alu_queue_drained", exp_q.size(), 0);
    check("key_queue_drained", key_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/keypad_alu_seq.md
# keypad_alu_seq

Parametrised successor to the 4-register keypad/ALU datapath. It combines:
- a debounced 4x4 keypad scanner;
- an NREGS x WIDTH register bank;
- an 8-operation ALU with registered carry and zero flags;
- a small sequencer that executes one operation per `start` and writes the result back.

It sits between the board switches/keypad and the output display pins of the top-level wrapper.

## Interface
Parameters:
- `WIDTH`, 8, datapath and register width (>= 4).
- `NREGS`, 4, register count, power of two >= 2. `AW = $clog2(NREGS)`.
- `SCAN_DIV`, 16, clock cycles each keypad column is driven (>= 2).
- `DEBOUNCE`, 4, consecutive identical full scans required to accept a key (>= 1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `kb_row`  in  4  keypad row sense, active-high.
- `kb_col`  out  4  one-hot column drive.
- `key_wr`  in  1  enables writing an accepted key code into `reg[addr_d]`.
- `start`  in  1  request one ALU operation; sampled only in IDLE.
- `op`  in  3  ALU operation select.
- `addr_a`, `addr_b`, `addr_d`  in  AW each  operand A, operand B and destination register.
- `busy`  out  1  sequencer not in IDLE.
- `done`  out  1  one-cycle pulse in the WB cycle.
- `result`  out  WIDTH  last ALU result (registered).
- `zero_flag`, `carry_flag`  out  1 each  registered flags.
- `key_valid`  out  1  one-cycle pulse on an accepted key.
- `key_code`  out  4  last accepted key code (registered).

## Operation
**Keypad scanner**
- Column index c cycles 0,1,2,3,0,…; each column is held for SCAN_DIV cycles, with `kb_col = 1<<c`.
- `kb_row` is sampled on the last cycle of each column slot.
- Code = c*4 + r, where r is the lowest set row index.
- When several keys are pressed, the lowest column wins, then the lowest row.
- A scan is evaluated at the end of the column-3 slot. The result is either a code or empty.
- A stability counter increments when a non-empty scan equals the previous scan, and resets to 1 otherwise.
- When the counter reaches DEBOUNCE and the key is armed:
  - `key_valid` pulses;
  - `key_code` updates;
  - the key disarms.
- The key re-arms only after one empty scan. Holding a key therefore produces exactly one pulse.

**Key write**
- If `key_wr=1` in the `key_valid` cycle, `reg[addr_d] <= {0, key_code}` (zero-extended).
- If an ALU writeback occurs in the same cycle, the ALU writeback wins. The key write is dropped, but `key_valid` still pulses.

**Sequencer FSM** (IDLE → READ → EXEC → WB → IDLE)
- IDLE: when `start=1`, latch `op`, `addr_a`, `addr_b`, `addr_d` and go to READ. Otherwise stay in IDLE.
- READ: latch `A = reg[addr_a]` and `B = reg[addr_b]`.
- EXEC: compute and register `result` and the flags.
- WB: `done=1`. `reg[addr_d] <= result` commits on the edge leaving WB.
- `start` is ignored outside IDLE.

**ALU ops** (all WIDTH bits; carry is bit WIDTH of the extended result)
- 000 ADD: A+B, carry = carry-out.
- 001 SUB: A-B, carry = 1 when there is no borrow (A >= B unsigned).
- 010 AND, 011 OR, 100 XOR: carry cleared.
- 101 SHL: A<<1, carry = A[WIDTH-1].
- 110 SHR: A>>1 (logical), carry = A[0].
- 111 MOV: A, carry cleared.
- All ops: `zero_flag = (result == 0)`.

## Timing
- `start` sampled at edge t: `busy` is high for t+1..t+3, `done` and the new `result`/flags are visible at t+3, and the register write is visible from t+4.
- Holding `start` high gives one operation every 4 cycles.
- An operation whose source equals the previous destination reads the updated value; no hazard is possible.
- `key_valid` is asserted in the cycle after the DEBOUNCE-th qualifying scan evaluation.
- Reset values:
  - `kb_col = 4'b0001`;
  - state IDLE, `busy = 0`, `done = 0`;
  - `result = 0`, both flags 0;
  - `key_valid = 0`, `key_code = 0`;
  - all registers 0, scan and debounce counters 0, key armed.
- Reset asserted mid-operation aborts it with no writeback. Operation resumes on the first edge after deassertion.

## Structure
- Package `keypad_alu_pkg` holds:
  - the `alu_op_t` enum (ADD…MOV encodings above);
  - the `seq_state_t` enum;
  - the `KEY_NONE` constant.
- Sub-module `kb_scanner` contains the column driver, row sampling, encoder and debounce logic. Its outputs are `key_valid` and `key_code`.
- The register bank, ALU and FSM stay in the top module.

## Test plan
Common setup: WIDTH=8, NREGS=4, SCAN_DIV=4, DEBOUNCE=2.
- Reset, then hold row 1 while column 2 is driven → one `key_valid` with `key_code = 9` after the 2nd full scan (about 32 cycles). There is no second pulse while the key is held; a new pulse follows release plus a re-press.
- Rows 0 and 2 pressed together in column 1 → `key_code = 4`.
- Key writes 0xF → r0 and 0x1 → r1. Then ADD a=0, b=1, d=2 → `result = 0x10`, carry 0, zero 0, `done` at t+3. Then SUB a=1, b=0 → `result = 0xF2`, carry 0.
- r0 = 0x80, SHL a=0 → `result = 0x00`, `zero_flag = 1`, `carry_flag = 1`. XOR r1, r1 → zero 1, carry 0.
- `start` held high for 12 cycles → exactly 3 `done` pulses. `start` while `busy` → ignored. `key_valid` coinciding with WB → ALU value stored in `reg[addr_d]`, key write dropped.
- `reset` asserted in EXEC → destination register unchanged, `busy = 0`, `result = 0` immediately.
